// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the pipelined adder datapath and its downstream stages.
package adder_pipe_pkg;

  localparam int ADDER_DATA_W = 64;
  localparam int ADDER_SUM_W  = ADDER_DATA_W + 1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/adder_result_fifo_sat_counter.sv
// Saturating up-counter; clear has priority and loads the same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= W'(i_inc);
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/adder_result_fifo.sv
// First-word-fall-through result FIFO behind the pipelined adder, with drop accounting.
// Optional registered almost-full output enabled by ADDER_RESULT_FIFO_AFULL_EN.
module adder_result_fifo
  import adder_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = ADDER_DATA_W,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 16,
  parameter int AFULL_THR  = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_en,
  input  logic [DATA_WIDTH:0]       i_sum,
  input  logic                      o_ready,
  output logic                      o_valid,
  output logic [DATA_WIDTH:0]       o_data,
  output logic                      o_carry,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_empty,
  input  logic                      i_clr,
  output logic                      o_ovf,
  output logic [CNT_W-1:0]          o_drop_cnt
`ifdef ADDER_RESULT_FIFO_AFULL_EN
  ,
  output logic                      o_afull
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THR);

  logic [DATA_WIDTH:0] r_mem [DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_count_nxt;
  logic                r_ovf;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && o_ready;
  // A full FIFO still accepts a sum when the head leaves in the same cycle.
  assign w_push  = i_en && (!w_full || w_pop);
  assign w_drop  = i_en && !w_push;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_nxt;
      if (i_clr) begin
        r_ovf <= 1'b0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_drop),
    .i_clr (i_clr),
    .o_cnt (o_drop_cnt)
  );

`ifdef ADDER_RESULT_FIFO_AFULL_EN
  logic r_afull;

  // Registered from the next occupancy so it tracks o_count in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_afull <= 1'b0;
    end else begin
      r_afull <= (w_count_nxt >= AFULL_C);
    end
  end

  assign o_afull = r_afull;
`else
  logic w_unused_afull;
  assign w_unused_afull = (r_count >= AFULL_C);
`endif

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rptr];
  assign o_carry = o_data[DATA_WIDTH];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_adder_result_fifo.sv
// Scoreboard bench for adder_result_fifo: driver models occupancy/drops, monitor checks output order.
module tb_adder_result_fifo;

  localparam int DW    = 64;
  localparam int SW    = DW + 1;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int THR   = 6;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_en = 1'b0;
  logic [SW-1:0]        i_sum = '0;
  logic                 o_ready = 1'b0;
  logic                 i_clr = 1'b0;
  logic                 o_valid;
  logic [SW-1:0]        o_data;
  logic                 o_carry;
  logic [3:0]           o_count;
  logic                 o_full;
  logic                 o_empty;
  logic                 o_ovf;
  logic [CNT_W-1:0]     o_drop_cnt;
`ifdef ADDER_RESULT_FIFO_AFULL_EN
  logic                 o_afull;
`endif

  adder_result_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W),
    .AFULL_THR  (THR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (i_en),
    .i_sum      (i_sum),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_carry    (o_carry),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .i_clr      (i_clr),
    .o_ovf      (o_ovf),
    .o_drop_cnt (o_drop_cnt)
`ifdef ADDER_RESULT_FIFO_AFULL_EN
    ,
    .o_afull    (o_afull)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference state: expected output order plus occupancy/overflow bookkeeping.
  logic [SW-1:0] sb [$];
  int            m_cnt = 0;
  logic          m_ovf = 1'b0;
  int            m_drop = 0;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_state();
    chk("count", SW'(o_count), SW'(m_cnt));
    chk("full",  SW'(o_full),  SW'(m_cnt == DEPTH));
    chk("empty", SW'(o_empty), SW'(m_cnt == 0));
    chk("ovf",   SW'(o_ovf),   SW'(m_ovf));
    chk("drop_cnt", SW'(o_drop_cnt), SW'(m_drop));
`ifdef ADDER_RESULT_FIFO_AFULL_EN
    chk("afull", SW'(o_afull), SW'(m_cnt >= THR));
`endif
  endtask

  // One clock of stimulus: check the state left by the previous edge, then drive and model this edge.
  task automatic step(input logic en, input logic [SW-1:0] sum, input logic rdy, input logic clr);
    bit pop, push, drop;
    @(posedge clk); #1;
    check_state();
    i_en = en; i_sum = sum; o_ready = rdy; i_clr = clr; rst_n = 1'b1;
    pop  = (m_cnt > 0) && rdy;
    push = en && ((m_cnt < DEPTH) || pop);
    drop = en && !push;
    if (push) sb.push_back(sum);
    m_cnt = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
    if (clr) begin
      m_ovf  = 1'b0;
      m_drop = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_drop < (1 << CNT_W) - 1) m_drop++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; i_en = 1'b0; o_ready = 1'b0; i_clr = 1'b0;
    sb.delete();
    m_cnt = 0; m_ovf = 1'b0; m_drop = 0;
  endtask

  function automatic logic [SW-1:0] rnd_sum();
    logic [SW-1:0] s;
    s = {1'($urandom_range(1, 0)), 32'($urandom), 32'($urandom)};
    return s;
  endfunction

  // Monitor: compares the presented head with the scoreboard, consuming on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_valid) begin
          if (sb.size() == 0) begin
            chk("valid_unexpected", SW'(o_valid), SW'(0));
          end else begin
            chk("data",  o_data, sb[0]);
            chk("carry", SW'(o_carry), SW'(sb[0][SW-1]));
            if (o_ready) void'(sb.pop_front());
          end
        end else begin
          chk("data_zero_when_empty", o_data, '0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [SW-1:0] s;
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b0, '0, 1'b0, 1'b0);

    // Single push with carry set
    step(1'b1, 65'h1_0000_0000_0000_0001, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill 1..8, then overflow by 3
    for (int i = 1; i <= 8; i++) step(1'b1, SW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, SW'(100 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    // Push and pop while full
    step(1'b1, SW'(9), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    // Drop and clear in the same cycle
    step(1'b1, SW'(200), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Pointer wrap: ready toggles, enable every third cycle
    for (int i = 0; i < 60; i++)
      step((i % 3) == 0, rnd_sum(), (i % 2) == 0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Randomised traffic including overflow and clears
    for (int i = 0; i < 400; i++)
      step($urandom_range(3, 0) != 0, rnd_sum(), $urandom_range(2, 0) == 0,
           $urandom_range(40, 0) == 0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-operation with 5 entries held and overflow set
    for (int i = 0; i < 10; i++) step(1'b1, SW'(50 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b0, 1'b0);
    s = 65'h0_FFFF_FFFF_FFFF_FFFF;
    step(1'b1, s, 1'b0, 1'b0);
    for (int i = 1; i < 7; i++) step(1'b1, SW'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    chk("scoreboard_drained", SW'(sb.size()), SW'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
